// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if: instruction-memory fetch bus between if_stage and imem.
//   imem_req   fetch request (stays high with a stable address until ready)
//   imem_addr  word-aligned fetch address
//   imem_ready memory accepts the request and returns imem_rdata this cycle
//   imem_rdata fetched instruction word
// master: fetch stage side; slave: instruction memory side.
// ---------------------------------------------------------------------------
interface if_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction fetch stage plus IF/ID pipeline register.
//
// Owns the PC, fetches one word per cycle from instruction memory over a
// req/ready handshake, and latches {instruction, PC+4} into IF/ID. Opcode
// (if_instr[31:26]) feeds the main control unit directly. Decode stalls are
// absorbed by a one-word skid buffer; taken branches and jumps flush IF/ID.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   stall               decode hazard: hold PC and IF/ID
//   branch_taken/target taken beq redirect (wins over jump)
//   jump/jump_target    j redirect
//   imem (master)       fetch bus: imem_req, imem_addr, imem_ready, imem_rdata
//   if_instr, if_pc4    IF/ID instruction and PC+4
//   if_valid            IF/ID holds a real instruction
//   opcode              if_instr[31:26]
//
// Optional build macro IF_STATS_EN adds saturating counters:
//   fetch_count         IF/ID loads with a valid instruction
//   bubble_count        clocks with if_valid=0 after reset release
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              jump,
    input  logic [31:0]       jump_target,
    if_stage_if.master        imem,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc4,
    output logic              if_valid,
    output logic [5:0]        opcode
`ifdef IF_STATS_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       bubble_count
`endif
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned OPW   = 6;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding
        HELD  = 2'd1,   // word parked in skid buffer during a stall
        DRAIN = 2'd2    // waiting out a request made stale by a redirect
    } state_t;

    state_t          state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [XLEN-1:0] skid_q, skid_n;
    logic [XLEN-1:0] pend_q, pend_n;
    logic [XLEN-1:0] instr_n, pc4_n;
    logic            valid_n;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            load;
    logic [XLEN-1:0] load_word;
    logic            flush;

    // Redirect selection: branch beats jump; low two bits are forced to zero.
    always_comb begin
        redirect = branch_taken | jump;
        target   = (branch_taken ? branch_target : jump_target) & ALIGN_MASK;
        pc_plus4 = pc_q + PC_STEP;  // wraps modulo 2^32
    end

    // Next-state and datapath control.
    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        skid_n    = skid_q;
        pend_n    = pend_q;
        instr_n   = if_instr;
        pc4_n     = if_pc4;
        valid_n   = if_valid;
        load      = 1'b0;
        load_word = skid_q;
        flush     = 1'b0;

        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (imem.imem_ready) begin
                        pc_n = target;
                    end else begin
                        // Request must stay stable; remember where to go.
                        pend_n  = target;
                        state_n = DRAIN;
                    end
                end else if (imem.imem_ready) begin
                    if (stall) begin
                        skid_n  = imem.imem_rdata;
                        state_n = HELD;
                    end else begin
                        load      = 1'b1;
                        load_word = imem.imem_rdata;
                    end
                end
            end

            HELD: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_n    = target;
                    state_n = FETCH;
                end else if (!stall) begin
                    load      = 1'b1;
                    load_word = skid_q;
                    state_n   = FETCH;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    flush = 1'b1;
                end
                if (imem.imem_ready) begin
                    pc_n    = redirect ? target : pend_q;
                    state_n = FETCH;
                end else if (redirect) begin
                    pend_n = target;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase

        // IF/ID load advances the PC by one word.
        if (load) begin
            instr_n = load_word;
            pc4_n   = pc_plus4;
            valid_n = 1'b1;
            pc_n    = pc_plus4;
        end

        if (flush) begin
            instr_n = NOP_WORD;
            pc4_n   = '0;
            valid_n = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_n;
        end
    end

    // PC, skid buffer, pending target and IF/ID register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC & ALIGN_MASK;
            skid_q   <= '0;
            pend_q   <= '0;
            if_instr <= NOP_WORD;
            if_pc4   <= '0;
            if_valid <= 1'b0;
        end else begin
            pc_q     <= pc_n;
            skid_q   <= skid_n;
            pend_q   <= pend_n;
            if_instr <= instr_n;
            if_pc4   <= pc4_n;
            if_valid <= valid_n;
        end
    end

    // Request drops immediately under reset so an in-flight fetch is abandoned.
    assign imem.imem_req  = ~reset & (state_q != HELD);
    assign imem.imem_addr = pc_q;
    assign opcode         = if_instr[XLEN-1 -: OPW];

`ifdef IF_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (load && !flush && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (!if_valid && (bubble_count != '1)) begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

    // Handshake: an unaccepted request keeps req high and addr stable.
    property p_req_stable;
        @(posedge clk) disable iff (reset)
            (imem.imem_req && !imem.imem_ready) |=> (imem.imem_req && $stable(imem.imem_addr));
    endproperty
    a_req_stable: assert property (p_req_stable);

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            jump;
    logic [XLEN-1:0] jump_target;
    logic            ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc4;
    logic            if_valid;
    logic [5:0]      opcode;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
        logic [XLEN-1:0] addr;
    } exp_t;

    exp_t sb[$];

    // Instruction memory contents: two fixed words, distinct pattern elsewhere.
    function automatic logic [XLEN-1:0] mem_word(input logic [XLEN-1:0] a);
        if (a == 32'h0000_0000) return 32'h8C01_0000;
        if (a == 32'h0000_0004) return 32'h0022_1820;
        return a ^ 32'h5A00_0000;
    endfunction

    if_stage_if bus ();

    assign bus.imem_ready = ready;
    assign bus.imem_rdata = ready ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;

`ifdef IF_STATS_EN
    logic [XLEN-1:0] fetch_count;
    logic [XLEN-1:0] bubble_count;
`endif

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem         (bus),
        .if_instr     (if_instr),
        .if_pc4       (if_pc4),
        .if_valid     (if_valid),
        .opcode       (opcode)
`ifdef IF_STATS_EN
        ,
        .fetch_count  (fetch_count),
        .bubble_count (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input logic e);
        check("imem_req", XLEN'(bus.imem_req), XLEN'(e));
    endtask

    // Queue the expected IF/ID and fetch address, clock once, then compare.
    task automatic tick(input logic [XLEN-1:0] ei, input logic [XLEN-1:0] ep,
                        input logic ev, input logic [XLEN-1:0] ea);
        exp_t e;
        sb.push_back('{instr: ei, pc4: ep, valid: ev, addr: ea});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("if_instr", if_instr, e.instr);
        check("if_pc4", if_pc4, e.pc4);
        check("if_valid", XLEN'(if_valid), XLEN'(e.valid));
        check("opcode", XLEN'(opcode), XLEN'(e.instr[31:26]));
        check("imem_addr", bus.imem_addr, e.addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        ready         = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc4", if_pc4, 32'h0);
        check("rst_if_valid", XLEN'(if_valid), 32'h0);
        check("rst_opcode", XLEN'(opcode), 32'h0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        chk_req(1'b0);

        // Sequential fetch at zero wait states.
        reset = 1'b0;
        #1;
        chk_req(1'b1);
        check("first_addr", bus.imem_addr, 32'h0);
        tick(32'h8C01_0000, 32'h4, 1'b1, 32'h4);
        check("opcode_lw", XLEN'(opcode), XLEN'(6'b100011));
        tick(32'h0022_1820, 32'h8, 1'b1, 32'h8);
        tick(mem_word(32'h8), 32'hC, 1'b1, 32'hC);
        tick(mem_word(32'hC), 32'h10, 1'b1, 32'h10);

        // Stall for three cycles at pc=0x10: word goes to the skid buffer.
        stall = 1'b1;
        tick(mem_word(32'hC), 32'h10, 1'b1, 32'h10);
        chk_req(1'b0);
        tick(mem_word(32'hC), 32'h10, 1'b1, 32'h10);
        tick(mem_word(32'hC), 32'h10, 1'b1, 32'h10);
        chk_req(1'b0);
        stall = 1'b0;
        tick(mem_word(32'h10), 32'h14, 1'b1, 32'h14);
        chk_req(1'b1);

        // Taken branch with ready=1.
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick(32'h0, 32'h0, 1'b0, 32'h40);
        branch_taken = 1'b0;
        tick(mem_word(32'h40), 32'h44, 1'b1, 32'h44);

        // Jump on the first of two wait cycles: stale word is drained.
        ready       = 1'b0;
        jump        = 1'b1;
        jump_target = 32'h100;
        tick(32'h0, 32'h0, 1'b0, 32'h44);
        chk_req(1'b1);
        jump = 1'b0;
        tick(32'h0, 32'h0, 1'b0, 32'h44);
        ready = 1'b1;
        tick(32'h0, 32'h0, 1'b0, 32'h100);
        tick(mem_word(32'h100), 32'h104, 1'b1, 32'h104);

        // PC wrap at the top of the address space.
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        tick(32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
        jump = 1'b0;
        tick(mem_word(32'hFFFF_FFFC), 32'h0, 1'b1, 32'h0);

        // Branch and jump together with stall: branch wins, stall ignored.
        branch_taken  = 1'b1;
        branch_target = 32'h20;
        jump          = 1'b1;
        jump_target   = 32'h80;
        stall         = 1'b1;
        tick(32'h0, 32'h0, 1'b0, 32'h20);
        chk_req(1'b1);
        branch_taken = 1'b0;
        jump         = 1'b0;
        stall        = 1'b0;
        tick(mem_word(32'h20), 32'h24, 1'b1, 32'h24);

        // Misaligned target is forced to a word; stall holds the bubble.
        branch_taken  = 1'b1;
        branch_target = 32'h203;
        tick(32'h0, 32'h0, 1'b0, 32'h200);
        branch_taken = 1'b0;
        stall        = 1'b1;
        tick(32'h0, 32'h0, 1'b0, 32'h200);
        chk_req(1'b0);
        tick(32'h0, 32'h0, 1'b0, 32'h200);
        stall = 1'b0;
        tick(mem_word(32'h200), 32'h204, 1'b1, 32'h204);

        // Redirect while HELD drops the skid word.
        stall = 1'b1;
        tick(mem_word(32'h200), 32'h204, 1'b1, 32'h204);
        jump        = 1'b1;
        jump_target = 32'h300;
        tick(32'h0, 32'h0, 1'b0, 32'h300);
        chk_req(1'b1);
        jump  = 1'b0;
        stall = 1'b0;
        tick(mem_word(32'h300), 32'h304, 1'b1, 32'h304);

        // Redirect arriving in DRAIN together with ready uses the new target.
        ready       = 1'b0;
        jump        = 1'b1;
        jump_target = 32'h400;
        tick(32'h0, 32'h0, 1'b0, 32'h304);
        jump          = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h500;
        ready         = 1'b1;
        tick(32'h0, 32'h0, 1'b0, 32'h500);
        branch_taken = 1'b0;
        tick(mem_word(32'h500), 32'h504, 1'b1, 32'h504);

        // Back-to-back redirects while draining keep the newest target.
        ready       = 1'b0;
        jump        = 1'b1;
        jump_target = 32'h600;
        tick(32'h0, 32'h0, 1'b0, 32'h504);
        jump_target = 32'h700;
        tick(32'h0, 32'h0, 1'b0, 32'h504);
        jump  = 1'b0;
        ready = 1'b1;
        tick(32'h0, 32'h0, 1'b0, 32'h700);
        tick(mem_word(32'h700), 32'h704, 1'b1, 32'h704);

        // Wait state plus stall: everything holds, request stays up.
        ready = 1'b0;
        stall = 1'b1;
        tick(mem_word(32'h700), 32'h704, 1'b1, 32'h704);
        chk_req(1'b1);
        ready = 1'b1;
        stall = 1'b0;
        tick(mem_word(32'h704), 32'h708, 1'b1, 32'h708);

        // Reset mid-request abandons the fetch immediately.
        ready = 1'b0;
        reset = 1'b1;
        #1;
        chk_req(1'b0);
        check("midrst_if_valid", XLEN'(if_valid), 32'h0);
        check("midrst_if_instr", if_instr, 32'h0);
        check("midrst_imem_addr", bus.imem_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ready = 1'b1;
        tick(32'h8C01_0000, 32'h4, 1'b1, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
